// File: rtl/diferential_muxgrid_if.sv
// diferential_muxgrid bus bundle.
// Config, run control, tap select and observation signals.
interface diferential_muxgrid_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int BITS  = 4,
  parameter int TAP_W = 4
);
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             run_en;
  logic [BITS-1:0]  data_in;
  logic [TAP_W-1:0] tap_sel;
  logic [ROWS-1:0]  row_out;
  logic [BITS-1:0]  tap_q;
  logic             cfg_busy;
  logic             cfg_done;
  logic [7:0]       step_cnt;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, run_en,
    output data_in, tap_sel,
    input  row_out, tap_q, cfg_busy, cfg_done, step_cnt
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, run_en,
    input  data_in, tap_sel,
    output row_out, tap_q, cfg_busy, cfg_done, step_cnt
  );
endinterface

// File: rtl/diferential_muxgrid.sv
// diferential_muxgrid: serially configured grid of registered cells.
// Each cell combines two selected neighbours with a 2-bit function.
module diferential_muxgrid #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int BITS  = 4,
  parameter int TAP_W = 4
) (
  input  logic clk,
  input  logic reset,
  diferential_muxgrid_if.slave bus
);
  localparam int CFG_W = 6;
  localparam int N     = ROWS * COLS;
  localparam int TOT   = CFG_W * N;
  localparam int CW    = $clog2(TOT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TOT-1:0]  cfg_q, cfg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      step_q, step_d;
  logic [BITS-1:0] cell_q [N];
  logic [BITS-1:0] cell_d [N];

  // State, config shift register and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // Next state; cfg_start always wins over a same-cycle cfg_valid.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_start) begin
          cnt_d = '0;
        end else if (bus.cfg_valid) begin
          cfg_d = {cfg_q[TOT-2:0], bus.cfg_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TOT - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating step counter; cleared whenever the grid is not running.
  always_comb begin
    step_d = '0;
    if (state_q == RUN && !bus.cfg_start) begin
      step_d = step_q;
      if (bus.run_en && step_q != 8'hFF)
        step_d = step_q + 8'd1;
    end
  end

  // Cell next values from registered neighbours only.
  always_comb begin
    logic [BITS-1:0] nb [4];
    logic [BITS-1:0] a, b, f;
    logic [CFG_W-1:0] cw;
    int up, lc, rc;
    a = '0;
    b = '0;
    f = '0;
    cw = '0;
    nb[0] = '0;
    nb[1] = '0;
    nb[2] = '0;
    nb[3] = '0;
    for (int k = 0; k < N; k++) cell_d[k] = '0;
    if (state_q == RUN && !bus.cfg_start) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          up = ((r + ROWS - 1) % ROWS) * COLS;
          lc = (c + COLS - 1) % COLS;
          rc = (c + 1) % COLS;
          cw = cfg_q[(r*COLS + c)*CFG_W +: CFG_W];
          nb[0] = cell_q[up + c];
          nb[1] = cell_q[up + lc];
          nb[2] = (c == 0) ? bus.data_in
                           : cell_q[r*COLS + lc];
          nb[3] = cell_q[r*COLS + rc];
          a = nb[cw[1:0]];
          b = nb[cw[3:2]];
          unique case (cw[5:4])
            2'd0:    f = a & b;
            2'd1:    f = a | b;
            2'd2:    f = a ^ b;
            default: f = a;
          endcase
          cell_d[r*COLS + c] = bus.run_en ? f : cell_q[r*COLS + c];
        end
      end
    end
  end

  // Cell registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) cell_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) cell_q[k] <= cell_d[k];
    end
  end

  // Tap mux; out-of-range indices read as zero.
  always_comb begin
    bus.tap_q = '0;
    for (int k = 0; k < N; k++)
      if (bus.tap_sel == TAP_W'(k)) bus.tap_q = cell_q[k];
  end

  // Last-column LSBs.
  always_comb begin
    bus.row_out = '0;
    for (int r = 0; r < ROWS; r++)
      bus.row_out[r] = cell_q[r*COLS + COLS - 1][0];
  end

  assign bus.cfg_busy = (state_q == LOAD);
  assign bus.cfg_done = (state_q == RUN);
  assign bus.step_cnt = step_q;
endmodule
